// File: rtl/lbdr_out_arbiter.sv
// rtl/lbdr_out_arbiter.sv - per-output round-robin packet arbiter with downstream credit gating

`ifndef HEADER
`define HEADER 3'b001
`endif
`ifndef PAYLOAD
`define PAYLOAD 3'b010
`endif
`ifndef TAIL
`define TAIL 3'b100
`endif

module lbdr_out_arbiter #(
    parameter int CREDITS = 4,
    parameter int CW      = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [4:0]    req,
    input  logic [14:0]   flit_id_vec,
    input  logic          credit_in,
    output logic [4:0]    grant,
    output logic          fwd,
    output logic          busy,
    output logic [CW-1:0] credit_cnt,
    output logic          credit_err
);

    localparam logic [CW-1:0] CMAX = CW'(CREDITS);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t     state;
    logic [2:0] owner;
    logic [2:0] rr_ptr;
    logic [2:0] pick;
    logic [2:0] idx;
    logic [3:0] sum;
    logic       found;
    logic [4:0] eligible;
    logic [2:0] fid [5];
    logic [2:0] owner_fid;
    logic       owner_req;

    always_comb begin
        eligible  = '0;
        owner_fid = '0;
        owner_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            fid[i]      = flit_id_vec[3*i +: 3];
            eligible[i] = req[i] && (fid[i] == `HEADER);
            if (owner == 3'(i)) begin
                owner_fid = fid[i];
                owner_req = req[i];
            end
        end
    end

    // Scan starting at rr_ptr with wrap mod 5; the first eligible HEADER wins.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < 5; k++) begin
            sum = {1'b0, rr_ptr} + 4'(k);
            if (sum >= 4'd5) sum = sum - 4'd5;
            idx = sum[2:0];
            if (!found && eligible[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign fwd = busy && owner_req && (credit_cnt != '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            grant      <= '0;
            busy       <= 1'b0;
            owner      <= '0;
            rr_ptr     <= '0;
            credit_cnt <= CMAX;
            credit_err <= 1'b0;
        end else begin
            if (fwd && !credit_in) begin
                credit_cnt <= credit_cnt - CW'(1);
            end else if (credit_in && !fwd) begin
                if (credit_cnt == CMAX) credit_err <= 1'b1;
                else                    credit_cnt <= credit_cnt + CW'(1);
            end

            case (state)
                IDLE: begin
                    if (found) begin
                        state <= ACTIVE;
                        owner <= pick;
                        grant <= 5'b00001 << pick;
                        busy  <= 1'b1;
                    end
                end
                ACTIVE: begin
                    // A HEADER on the owner here is just another flit; only TAIL releases.
                    if (fwd && owner_fid == `TAIL) begin
                        state  <= IDLE;
                        grant  <= '0;
                        busy   <= 1'b0;
                        rr_ptr <= (owner == 3'd4) ? 3'd0 : owner + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
